// File: rtl/ram_readback.sv
// rtl/ram_readback.sv - sequential RAM sweep reader with valid/ready word stream; optional READBACK_CHECKSUM_EN
module ram_readback #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [DATA_W-1:0] word_data,
    output logic [ADDR_W-1:0] word_addr,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, OUT, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic [2:0]      wait_cnt;
    logic            capture;

    // mem_q is valid on the last WAIT cycle; that is the only cycle it is sampled
    assign capture = (state == WAIT) && (wait_cnt == WAIT_LAST);

    // Sweep controller: owns the RAM port from READ through OUT, all outputs registered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            remaining  <= '0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_rden   <= 1'b0;
            busy       <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_addr  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= count;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem_addr <= base_addr;
                            mem_rden <= 1'b1;
                            busy     <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    mem_rden <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        word_data  <= mem_q;
                        word_addr  <= mem_addr;
                        word_valid <= 1'b1;
                        remaining  <= remaining - 1'b1;
                        state      <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (remaining != '0) begin
                            // address wraps naturally at 2^ADDR_W
                            mem_addr <= mem_addr + 1'b1;
                            mem_rden <= 1'b1;
                            state    <= READ;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Running modulo-2^DATA_W sum of captured words, cleared when a sweep is accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sum_q <= '0;
        end else if (state == IDLE && start) begin
            sum_q <= '0;
        end else if (capture) begin
            sum_q <= sum_q + mem_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule
